riscv_hazard_scoreboard: RTL and testbench

//  Parametrised scoreboard hazard unit between ID and EX; generalises single-load-use detection.

---
 rtl/riscv_hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_riscv_hazard_scoreboard.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_scoreboard.sv
// Scoreboard hazard unit between ID and EX: tracks in-flight register writes with fixed or variable latency.
// Optional stall-cycle performance counter enabled by defining RISCV_HAZ_PERF_EN.
module riscv_hazard_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int LAT_W    = 3,
  parameter int NUM_REGS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [NUM_SRC*5-1:0]   id_rs_addr,
  input  logic [NUM_SRC-1:0]     id_rs_used,
  input  logic [4:0]             id_rd_addr,
  input  logic                   id_rd_wr,
  input  logic [LAT_W-1:0]       id_lat,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd_addr,
  input  logic                   pipe_flush,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   flush_ex,
  output logic [NUM_SRC-1:0]     hazard_rs,
  output logic                   sb_busy,
  output logic [31:0]            perf_stall_cnt
);

  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  // x0 is never tracked, so per-register state starts at index 1
  logic [LAT_W-1:0]    cnt [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] lng;
  logic [31:0]         pend_all;
  logic [NUM_REGS-1:1] issue_hit;
  logic [NUM_REGS-1:1] wb_hit;
  logic [NUM_SRC-1:0]  raw;
  logic [4:0]          rs;
  logic                waw;
  logic                haz;
  logic                stall;
  logic                issue;

  always_comb begin
    pend_all = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      pend_all[r] = (cnt[r] != '0) | lng[r];
    end
  end

  always_comb begin
    raw = '0;
    rs  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      rs     = id_rs_addr[5*k +: 5];
      raw[k] = id_valid & id_rs_used[k] & (rs != '0) & pend_all[rs];
    end
  end

  assign waw   = id_valid & id_rd_wr & (id_rd_addr != '0) & pend_all[id_rd_addr];
  assign haz   = (|raw) | waw;
  assign stall = haz & ~pipe_flush;
  assign issue = id_valid & ~haz & ~pipe_flush & id_rd_wr &
                 (id_rd_addr != '0) & (id_lat != '0);

  always_comb begin
    issue_hit = '0;
    wb_hit    = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      issue_hit[r] = issue & (id_rd_addr == 5'(r));
      wb_hit[r]    = wb_valid & (wb_rd_addr == 5'(r));
    end
  end

  // Issue outranks countdown/flush on cnt and outranks write-back on lng
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lng <= '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (issue_hit[r] && (id_lat != LAT_MAX)) begin
          cnt[r] <= id_lat;
        end else if (pipe_flush) begin
          cnt[r] <= '0;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - LAT_ONE;
        end

        if (issue_hit[r] && (id_lat == LAT_MAX)) begin
          lng[r] <= 1'b1;
        end else if (wb_hit[r]) begin
          lng[r] <= 1'b0;
        end
      end
    end
  end

  assign stall_if  = stall;
  assign stall_id  = stall;
  assign flush_ex  = stall;
  assign hazard_rs = raw;
  assign sb_busy   = |pend_all;

`ifdef RISCV_HAZ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (stall) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed bench for riscv_hazard_scoreboard: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_riscv_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd_addr;
  logic        id_rd_wr;
  logic [2:0]  id_lat;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        pipe_flush;
  logic        stall_if;
  logic        stall_id;
  logic        flush_ex;
  logic [1:0]  hazard_rs;
  logic        sb_busy;
  logic [31:0] perf_stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_perf = 0;

  riscv_hazard_scoreboard #(.NUM_SRC(2), .LAT_W(3), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr), .id_rd_wr(id_rd_wr),
    .id_lat(id_lat), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .pipe_flush(pipe_flush), .stall_if(stall_if), .stall_id(stall_id),
    .flush_ex(flush_ex), .hazard_rs(hazard_rs), .sb_busy(sb_busy),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       wr;
    logic [2:0] lat;
    logic       wbv;
    logic [4:0] wbrd;
    logic       fl;
    logic       es;
    logic [1:0] ehrs;
    logic       eb;
  } vec_t;

  function automatic vec_t mk(logic v, logic [4:0] rs0, logic [4:0] rs1, logic [1:0] used,
                              logic [4:0] rd, logic wr, logic [2:0] lat, logic wbv,
                              logic [4:0] wbrd, logic fl, logic es, logic [1:0] ehrs, logic eb);
    vec_t t;
    t.v = v; t.rs0 = rs0; t.rs1 = rs1; t.used = used; t.rd = rd; t.wr = wr; t.lat = lat;
    t.wbv = wbv; t.wbrd = wbrd; t.fl = fl; t.es = es; t.ehrs = ehrs; t.eb = eb;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid   = t.v;
    id_rs_addr = {t.rs1, t.rs0};
    id_rs_used = t.used;
    id_rd_addr = t.rd;
    id_rd_wr   = t.wr;
    id_lat     = t.lat;
    wb_valid   = t.wbv;
    wb_rd_addr = t.wbrd;
    pipe_flush = t.fl;
  endtask

  // Drive at negedge, check before the next posedge, return on the following negedge
  task automatic run_vec(input vec_t t, input string tag);
    apply(t);
    #2;
    check({tag, ".stall_if"}, 32'(stall_if), 32'(t.es));
    check({tag, ".stall_id"}, 32'(stall_id), 32'(t.es));
    check({tag, ".flush_ex"}, 32'(flush_ex), 32'(t.es));
    check({tag, ".hazard_rs"}, 32'(hazard_rs), 32'(t.ehrs));
    check({tag, ".sb_busy"}, 32'(sb_busy), 32'(t.eb));
    if (t.es) exp_perf++;
    @(negedge clk);
  endtask

  task automatic check_perf(input string tag);
`ifdef RISCV_HAZ_PERF_EN
    check(tag, perf_stall_cnt, 32'(exp_perf));
`else
    check(tag, perf_stall_cnt, 32'h0);
`endif
  endtask

  vec_t tbl [23];
  vec_t nop;

  initial begin
    nop = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    //           v rs0 rs1 used  rd wr lat wbv wbrd fl es ehrs  eb
    tbl[0]  = mk(1,  1,  0, 2'b01, 5, 1, 1, 0, 0, 0, 0, 2'b00, 0); // load x5, lat 1
    tbl[1]  = mk(1,  5,  7, 2'b11, 6, 1, 1, 0, 0, 0, 1, 2'b01, 1); // add x6,x5,x7: load-use
    tbl[2]  = mk(1,  5,  7, 2'b11, 6, 1, 1, 0, 0, 0, 0, 2'b00, 0); // proceeds, x6 lat 1
    tbl[3]  = nop; tbl[3].eb = 1;
    tbl[4]  = nop;
    tbl[5]  = mk(1,  1,  0, 2'b01, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0); // load x0
    tbl[6]  = mk(1,  0,  0, 2'b01, 8, 1, 0, 0, 0, 0, 0, 2'b00, 0); // read x0
    tbl[7]  = nop;
    tbl[8]  = mk(1,  0,  0, 2'b00, 3, 1, 3, 0, 0, 0, 0, 2'b00, 0); // mul x3, lat 3
    tbl[9]  = mk(1,  3,  0, 2'b01, 4, 1, 1, 0, 0, 1, 0, 2'b01, 1); // flush with x3 reader in ID
    tbl[10] = mk(1,  3,  0, 2'b01, 4, 1, 1, 0, 0, 0, 0, 2'b00, 0); // cnt[3] cleared by flush
    tbl[11] = nop; tbl[11].eb = 1;
    tbl[12] = nop;
    tbl[13] = mk(1,  0,  0, 2'b00, 10, 1, 3, 0, 0, 0, 0, 2'b00, 0); // x10, lat 3
    tbl[14] = mk(1,  1, 10, 2'b11, 11, 1, 1, 0, 0, 0, 1, 2'b10, 1); // slot 1 RAW, 3 cycles
    tbl[15] = mk(1,  1, 10, 2'b11, 11, 1, 1, 0, 0, 0, 1, 2'b10, 1);
    tbl[16] = mk(1,  1, 10, 2'b11, 11, 1, 1, 0, 0, 0, 1, 2'b10, 1);
    tbl[17] = mk(1,  1, 10, 2'b11, 11, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    tbl[18] = mk(1,  0,  0, 2'b00, 11, 1, 2, 0, 0, 0, 1, 2'b00, 1); // fixed-latency WAW on x11
    tbl[19] = mk(1,  0,  0, 2'b00, 11, 1, 2, 0, 0, 0, 0, 2'b00, 0);
    tbl[20] = mk(1, 11,  0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1); // pending reg in unused slot
    tbl[21] = mk(0, 11,  0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1); // id_valid low
    tbl[22] = nop;

    apply(nop);
    rst_n = 1'b0;
    #2;
    check("reset.stall_if", 32'(stall_if), 32'h0);
    check("reset.sb_busy", 32'(sb_busy), 32'h0);
    check("reset.perf", perf_stall_cnt, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Variable-latency div on x9: reader held 20 cycles, WAW div inside the wait
    run_vec(mk(1, 1, 2, 2'b11, 9, 1, 7, 0, 0, 0, 0, 2'b00, 0), "div_issue");
    for (int i = 0; i < 20; i++) begin
      if (i == 5)
        run_vec(mk(1, 0, 0, 2'b00, 9, 1, 7, 0, 0, 0, 1, 2'b00, 1), "div_waw");
      else
        run_vec(mk(1, 9, 7, 2'b11, 12, 1, 0, (i == 19), 9, 0, 1, 2'b01, 1),
                $sformatf("div_wait%0d", i));
    end
    run_vec(mk(1, 9, 7, 2'b11, 12, 1, 0, 0, 0, 0, 0, 2'b00, 0), "div_release");

    // Flush clears fixed-latency entries but keeps the pending div
    run_vec(mk(1, 0, 0, 2'b00, 9, 1, 7, 0, 0, 0, 0, 2'b00, 0), "flush.div");
    run_vec(mk(1, 0, 0, 2'b00, 3, 1, 3, 0, 0, 0, 0, 2'b00, 1), "flush.mul");
    run_vec(mk(1, 3, 0, 2'b01, 13, 1, 0, 0, 0, 1, 0, 2'b01, 1), "flush.cycle");
    run_vec(mk(1, 3, 0, 2'b01, 13, 1, 0, 0, 0, 0, 0, 2'b00, 1), "flush.rd_x3");
    run_vec(mk(1, 0, 9, 2'b10, 13, 1, 0, 0, 0, 0, 1, 2'b10, 1), "flush.rd_x9");

    // Write-back and a new div to the same register in one cycle: issue wins
    run_vec(mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 9, 0, 0, 2'b00, 1), "wbiss.wb");
    run_vec(mk(1, 0, 0, 2'b00, 9, 1, 7, 1, 9, 0, 0, 2'b00, 0), "wbiss.both");
    run_vec(mk(1, 9, 0, 2'b01, 12, 1, 0, 0, 0, 0, 1, 2'b01, 1), "wbiss.rd_x9");
    check_perf("perf.before_reset");

    // Asynchronous reset in the middle of a stall
    apply(mk(1, 9, 0, 2'b01, 12, 1, 0, 0, 0, 0, 1, 2'b01, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.stall_if", 32'(stall_if), 32'h0);
    check("midrst.flush_ex", 32'(flush_ex), 32'h0);
    check("midrst.hazard_rs", 32'(hazard_rs), 32'h0);
    check("midrst.sb_busy", 32'(sb_busy), 32'h0);
    check("midrst.perf", perf_stall_cnt, 32'h0);
    exp_perf = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("postrst.stall_id", 32'(stall_id), 32'h0);
    check("postrst.sb_busy", 32'(sb_busy), 32'h0);
    @(negedge clk);
    run_vec(mk(1, 9, 0, 2'b01, 12, 1, 0, 0, 0, 0, 0, 2'b00, 0), "postrst.rd_x9");
    check_perf("perf.after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
